// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the ALU/MDU slice.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SLTU  = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_NOR   = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SLT   = 4'b0111,
        OP_MULTU = 4'b1000,
        OP_DIVU  = 4'b1001,
        OP_MFHI  = 4'b1010,
        OP_MFLO  = 4'b1011
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mdu_if.sv
// Request/response bundle between a requester and alu_mdu.
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic             valid_in;
    logic             ready_out;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             valid_out;

    modport master (
        output valid_in, op, a, b,
        input  ready_out, result, zero, overflow, valid_out
    );

    modport slave (
        input  valid_in, op, a, b,
        output ready_out, result, zero, overflow, valid_out
    );
endinterface

// File: rtl/alu_mdu_iter.sv
// One shift-add multiply or restoring-divide step per enable.
// Working pair {hi,lo}: product accumulator / {remainder,quotient}.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_en,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi_nxt,
    output logic [WIDTH-1:0] o_lo_nxt
);
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;

    // Next working pair for one multiply or divide step.
    always_comb begin
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_rem_sh = {r_hi, r_lo[WIDTH-1]};
        w_diff   = w_rem_sh - {1'b0, r_b};
        if (i_div) begin
            if (!w_diff[WIDTH]) begin
                o_hi_nxt = w_diff[WIDTH-1:0];
                o_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                o_hi_nxt = w_rem_sh[WIDTH-1:0];
                o_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            o_hi_nxt = w_sum[WIDTH:1];
            o_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    // Latch operands on load, advance one step per enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
            r_b  <= '0;
        end else if (i_load) begin
            r_hi <= '0;
            r_lo <= i_a;
            r_b  <= i_b;
        end else if (i_en) begin
            r_hi <= o_hi_nxt;
            r_lo <= o_lo_nxt;
        end
    end
endmodule

// File: rtl/alu_mdu.sv
// Single-cycle ALU plus iterative unsigned multiply/divide with HI/LO.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic     clk,
    input  logic     reset,
    alu_mdu_if.slave bus
);
    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_zero;
    logic             r_overflow;
    logic             r_valid_out;

    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ovf;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;
    logic             w_accept;
    logic             w_b_zero;
    logic             w_load;
    logic             w_last;

    assign w_accept = bus.valid_in && (r_state == ST_IDLE);
    assign w_b_zero = (bus.b == '0);
    assign w_load   = w_accept && ((bus.op == OP_MULTU) || ((bus.op == OP_DIVU) && !w_b_zero));
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_en     (r_state != ST_IDLE),
        .i_div    (r_state == ST_DIV),
        .i_a      (bus.a),
        .i_b      (bus.b),
        .o_hi_nxt (w_hi_nxt),
        .o_lo_nxt (w_lo_nxt)
    );

    // Single-cycle datapath: logic, arithmetic, compares, HI/LO reads.
    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        w_sum     = bus.a + bus.b;
        w_diff    = bus.a - bus.b;
        case (bus.op)
            OP_AND:  w_alu_res = bus.a & bus.b;
            OP_OR:   w_alu_res = bus.a | bus.b;
            OP_XOR:  w_alu_res = bus.a ^ bus.b;
            OP_NOR:  w_alu_res = ~(bus.a | bus.b);
            OP_ADD: begin
                w_alu_res = w_sum;
                w_alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_MFHI: w_alu_res = r_hi;
            OP_MFLO: w_alu_res = r_lo;
            default: w_alu_res = '0;
        endcase
    end

    // Control FSM with registered result, flags, HI/LO and completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_result    <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_zero      <= 1'b1;
            r_overflow  <= 1'b0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.valid_in) begin
                        r_cnt <= '0;
                        if (bus.op == OP_MULTU) begin
                            r_state <= ST_MUL;
                        end else if ((bus.op == OP_DIVU) && !w_b_zero) begin
                            r_state <= ST_DIV;
                        end else if (bus.op == OP_DIVU) begin
                            // Divide by zero resolves immediately without iterating.
                            r_lo        <= '1;
                            r_hi        <= bus.a;
                            r_result    <= '1;
                            r_zero      <= 1'b0;
                            r_overflow  <= 1'b0;
                            r_valid_out <= 1'b1;
                        end else begin
                            r_result    <= w_alu_res;
                            r_zero      <= (w_alu_res == '0);
                            r_overflow  <= w_alu_ovf;
                            r_valid_out <= 1'b1;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state     <= ST_IDLE;
                        r_hi        <= w_hi_nxt;
                        r_lo        <= w_lo_nxt;
                        r_result    <= w_lo_nxt;
                        r_zero      <= (w_lo_nxt == '0);
                        r_overflow  <= 1'b0;
                        r_valid_out <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready_out = (r_state == ST_IDLE);
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.overflow  = r_overflow;
    assign bus.valid_out = r_valid_out;
endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench: directed corner cases plus randomized traffic on
// WIDTH=32 and WIDTH=8 instances, checked against an arithmetic model.
module tb_alu_mdu;
    import alu_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] m_hi [2];
    logic [31:0] m_lo [2];

    alu_mdu_if #(.WIDTH(32)) bus32 ();
    alu_mdu_if #(.WIDTH(8))  bus8 ();

    alu_mdu #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    alu_mdu #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic drive(input bit w8, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            bus8.valid_in = v; bus8.op = op; bus8.a = a[7:0]; bus8.b = b[7:0];
        end else begin
            bus32.valid_in = v; bus32.op = op; bus32.a = a; bus32.b = b;
        end
    endtask

    task automatic sample(input bit w8, output logic [31:0] res, output logic z,
                          output logic ov, output logic vo, output logic rdy);
        if (w8) begin
            res = {24'd0, bus8.result}; z = bus8.zero; ov = bus8.overflow;
            vo = bus8.valid_out; rdy = bus8.ready_out;
        end else begin
            res = bus32.result; z = bus32.zero; ov = bus32.overflow;
            vo = bus32.valid_out; rdy = bus32.ready_out;
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural rules.
    task automatic model(input bit w8, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] er,
                         output logic eo, output int elat);
        int w, idx;
        longint unsigned full, msk, ua, ub, r, p;
        longint half, sa, sb, s;
        w    = w8 ? 8 : 32;
        idx  = w8 ? 1 : 0;
        full = 64'd1 << w;
        msk  = full - 1;
        ua   = {32'd0, a} & msk;
        ub   = {32'd0, b} & msk;
        half = longint'(full >> 1);
        sa   = (ua >= (full >> 1)) ? longint'(ua) - longint'(full) : longint'(ua);
        sb   = (ub >= (full >> 1)) ? longint'(ub) - longint'(full) : longint'(ub);
        r = 0; eo = 1'b0; elat = 1;
        case (op)
            OP_AND:  r = ua & ub;
            OP_OR:   r = ua | ub;
            OP_XOR:  r = ua ^ ub;
            OP_NOR:  r = ~(ua | ub) & msk;
            OP_ADD:  begin s = sa + sb; r = (ua + ub) & msk; eo = (s >= half) || (s < -half); end
            OP_SUB:  begin s = sa - sb; r = (ua - ub) & msk; eo = (s >= half) || (s < -half); end
            OP_SLT:  r = (sa < sb) ? 1 : 0;
            OP_SLTU: r = (ua < ub) ? 1 : 0;
            OP_MULTU: begin
                p = ua * ub;
                m_hi[idx] = 32'((p >> w) & msk);
                m_lo[idx] = 32'(p & msk);
                r = p & msk; elat = w + 1;
            end
            OP_DIVU: begin
                if (ub == 0) begin
                    m_lo[idx] = 32'(msk); m_hi[idx] = 32'(ua); r = msk;
                end else begin
                    m_lo[idx] = 32'(ua / ub); m_hi[idx] = 32'(ua % ub);
                    r = ua / ub; elat = w + 1;
                end
            end
            OP_MFHI: r = {32'd0, m_hi[idx]};
            OP_MFLO: r = {32'd0, m_lo[idx]};
            default: r = 0;
        endcase
        er = 32'(r);
    endtask

    // Issue one request from an idle DUT, scramble operands after accept,
    // and wait (bounded) for its completion pulse.
    task automatic transact(input bit w8, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, output logic [31:0] res,
                            output logic z, output logic ov, output int cyc);
        logic vo, rdy;
        drive(w8, 1'b1, op, a, b);
        @(posedge clk); #1;
        drive(w8, 1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom);
        cyc = 1;
        sample(w8, res, z, ov, vo, rdy);
        while (!vo && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            sample(w8, res, z, ov, vo, rdy);
        end
    endtask

    function automatic logic [31:0] pick(input bit w8);
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return w8 ? 32'h80 : 32'h8000_0000;
            3: return w8 ? 32'h7F : 32'h7FFF_FFFF;
            4: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        logic [31:0] res; logic z, ov, vo, rdy;
        reset = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            sample(w[0], res, z, ov, vo, rdy);
            checks++; if (res !== 32'd0) begin failures++; $display("FAIL reset_result w8=%0d got=%h exp=0", w, res); end
            checks++; if (z !== 1'b1)    begin failures++; $display("FAIL reset_zero w8=%0d got=%b exp=1", w, z); end
            checks++; if (ov !== 1'b0)   begin failures++; $display("FAIL reset_ovf w8=%0d got=%b exp=0", w, ov); end
            checks++; if (vo !== 1'b0)   begin failures++; $display("FAIL reset_valid w8=%0d got=%b exp=0", w, vo); end
            checks++; if (rdy !== 1'b1)  begin failures++; $display("FAIL reset_ready w8=%0d got=%b exp=1", w, rdy); end
            m_hi[w] = 32'd0; m_lo[w] = 32'd0;
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] res; logic z, ov; int cyc;
        transact(1'b0, OP_ADD, 32'h7FFF_FFFF, 32'd1, res, z, ov, cyc);
        checks++; if (res !== 32'h8000_0000) begin failures++; $display("FAIL add_ovf_result got=%h exp=80000000", res); end
        checks++; if (ov !== 1'b1) begin failures++; $display("FAIL add_ovf_flag got=%b exp=1", ov); end
        checks++; if (cyc !== 1)   begin failures++; $display("FAIL add_latency got=%0d exp=1", cyc); end
        @(posedge clk); #1;
        transact(1'b0, OP_SLT, 32'hFFFF_FFFF, 32'd1, res, z, ov, cyc);
        checks++; if (res !== 32'd1) begin failures++; $display("FAIL slt_neg got=%h exp=1", res); end
        @(posedge clk); #1;
        transact(1'b0, OP_SLTU, 32'hFFFF_FFFF, 32'd1, res, z, ov, cyc);
        checks++; if (res !== 32'd0) begin failures++; $display("FAIL sltu_big got=%h exp=0", res); end
        checks++; if (z !== 1'b1)    begin failures++; $display("FAIL sltu_zero got=%b exp=1", z); end
        @(posedge clk); #1;
        transact(1'b0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, z, ov, cyc);
        checks++; if (res !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", res); end
        checks++; if (cyc !== 33) begin failures++; $display("FAIL multu_latency got=%0d exp=33", cyc); end
        @(posedge clk); #1;
        transact(1'b0, OP_MFHI, 32'd0, 32'd0, res, z, ov, cyc);
        checks++; if (res !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_mfhi got=%h exp=fffffffe", res); end
        @(posedge clk); #1;
        transact(1'b0, OP_DIVU, 32'd100, 32'd7, res, z, ov, cyc);
        checks++; if (res !== 32'd14) begin failures++; $display("FAIL divu_lo got=%0d exp=14", res); end
        checks++; if (cyc !== 33)     begin failures++; $display("FAIL divu_latency got=%0d exp=33", cyc); end
        @(posedge clk); #1;
        transact(1'b0, OP_MFHI, 32'd0, 32'd0, res, z, ov, cyc);
        checks++; if (res !== 32'd2) begin failures++; $display("FAIL divu_rem got=%0d exp=2", res); end
        @(posedge clk); #1;
        transact(1'b0, OP_DIVU, 32'd5, 32'd0, res, z, ov, cyc);
        checks++; if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div0_result got=%h exp=ffffffff", res); end
        checks++; if (cyc !== 1) begin failures++; $display("FAIL div0_latency got=%0d exp=1", cyc); end
        checks++; if (z !== 1'b0) begin failures++; $display("FAIL div0_zero got=%b exp=0", z); end
        @(posedge clk); #1;
        transact(1'b0, 4'b1100, 32'd3, 32'd4, res, z, ov, cyc);
        checks++; if (res !== 32'd0 || z !== 1'b1 || ov !== 1'b0 || cyc !== 1) begin
            failures++; $display("FAIL invalid_op got res=%h z=%b ov=%b cyc=%0d exp res=0 z=1 ov=0 cyc=1", res, z, ov, cyc);
        end
        @(posedge clk); #1;
        transact(1'b0, OP_MFHI, 32'd0, 32'd0, res, z, ov, cyc);
        checks++; if (res !== 32'd5) begin failures++; $display("FAIL div0_hi_held got=%h exp=5", res); end
        @(posedge clk); #1;
        transact(1'b0, OP_MFLO, 32'd0, 32'd0, res, z, ov, cyc);
        checks++; if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div0_lo_held got=%h exp=ffffffff", res); end
        m_hi[0] = 32'd5; m_lo[0] = 32'hFFFF_FFFF;
        @(posedge clk); #1;
    endtask

    task automatic test_busy_hold();
        logic [31:0] a, b, er, res; logic eo, z, ov, vo, rdy, rdy_seen; int elat, cyc;
        a = $urandom; b = $urandom;
        model(1'b0, OP_MULTU, a, b, er, eo, elat);
        drive(1'b0, 1'b1, OP_MULTU, a, b);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, OP_ADD, 32'd3, 32'd4);
        cyc = 1; rdy_seen = 1'b0;
        sample(1'b0, res, z, ov, vo, rdy);
        while (!vo && cyc < 200) begin
            if (rdy) rdy_seen = 1'b1;
            @(posedge clk); #1;
            cyc++;
            sample(1'b0, res, z, ov, vo, rdy);
        end
        checks++; if (cyc !== elat) begin failures++; $display("FAIL hold_mul_latency got=%0d exp=%0d", cyc, elat); end
        checks++; if (res !== er)   begin failures++; $display("FAIL hold_mul_lo got=%h exp=%h", res, er); end
        checks++; if (rdy_seen !== 1'b0) begin failures++; $display("FAIL hold_busy_ready got=%b exp=0", rdy_seen); end
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL hold_ready_at_done got=%b exp=1", rdy); end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, OP_AND, 32'd0, 32'd0);
        sample(1'b0, res, z, ov, vo, rdy);
        checks++; if (vo !== 1'b1 || res !== 32'd7) begin
            failures++; $display("FAIL hold_add_accept got vo=%b res=%h exp vo=1 res=7", vo, res);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random(input bit w8, input int n);
        logic [31:0] a, b, er, res; logic [3:0] op; logic eo, z, ov, vo, rdy; int elat, cyc;
        for (int i = 0; i < n; i++) begin
            op = 4'($urandom_range(0, 15));
            a = pick(w8); b = pick(w8);
            model(w8, op, a, b, er, eo, elat);
            transact(w8, op, a, b, res, z, ov, cyc);
            checks++; if (res !== er) begin failures++; $display("FAIL rand_result w8=%0d op=%h a=%h b=%h got=%h exp=%h", w8, op, a, b, res, er); end
            checks++; if (ov !== eo)  begin failures++; $display("FAIL rand_ovf w8=%0d op=%h a=%h b=%h got=%b exp=%b", w8, op, a, b, ov, eo); end
            checks++; if (z !== (er == 32'd0)) begin failures++; $display("FAIL rand_zero w8=%0d op=%h got=%b exp=%b", w8, op, z, (er == 32'd0)); end
            checks++; if (cyc !== elat) begin failures++; $display("FAIL rand_latency w8=%0d op=%h got=%0d exp=%0d", w8, op, cyc, elat); end
            @(posedge clk); #1;
            sample(w8, res, z, ov, vo, rdy);
            checks++; if (vo !== 1'b0) begin failures++; $display("FAIL rand_pulse w8=%0d op=%h got=%b exp=0", w8, op, vo); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] er, res; logic eo, z, ov, vo, rdy; int elat, cyc;
        model(1'b1, OP_MULTU, 32'd15, 32'd17, er, eo, elat);
        drive(1'b1, 1'b1, OP_MULTU, 32'd15, 32'd17);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, OP_AND, 32'd0, 32'd0);
        cyc = 1;
        sample(1'b1, res, z, ov, vo, rdy);
        while (!vo && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            sample(1'b1, res, z, ov, vo, rdy);
        end
        checks++; if (cyc !== 9)        begin failures++; $display("FAIL b2b_mul_latency got=%0d exp=9", cyc); end
        checks++; if (res !== 32'hFF)   begin failures++; $display("FAIL b2b_mul_lo got=%h exp=ff", res); end
        checks++; if (rdy !== 1'b1)     begin failures++; $display("FAIL b2b_ready got=%b exp=1", rdy); end
        model(1'b1, OP_ADD, 32'h70, 32'h20, er, eo, elat);
        drive(1'b1, 1'b1, OP_ADD, 32'h70, 32'h20);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, OP_AND, 32'd0, 32'd0);
        sample(1'b1, res, z, ov, vo, rdy);
        checks++; if (vo !== 1'b1 || res !== er || ov !== eo) begin
            failures++; $display("FAIL b2b_add got vo=%b res=%h ov=%b exp vo=1 res=%h ov=%b", vo, res, ov, er, eo);
        end
        @(posedge clk); #1;
        model(1'b1, OP_MFHI, 32'd0, 32'd0, er, eo, elat);
        transact(1'b1, OP_MFHI, 32'd0, 32'd0, res, z, ov, cyc);
        checks++; if (res !== er) begin failures++; $display("FAIL b2b_mfhi got=%h exp=%h", res, er); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] res; logic z, ov, vo, rdy; int vo_seen, cyc;
        vo_seen = 0;
        drive(1'b0, 1'b1, OP_MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, OP_AND, 32'd0, 32'd0);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            sample(1'b0, res, z, ov, vo, rdy);
            if (vo) vo_seen++;
        end
        #2 reset = 1'b1;
        #1;
        sample(1'b0, res, z, ov, vo, rdy);
        checks++; if (rdy !== 1'b1 || vo !== 1'b0 || res !== 32'd0 || z !== 1'b1) begin
            failures++; $display("FAIL midreset_state got rdy=%b vo=%b res=%h z=%b exp rdy=1 vo=0 res=0 z=1", rdy, vo, res, z);
        end
        m_hi[0] = 32'd0; m_lo[0] = 32'd0; m_hi[1] = 32'd0; m_lo[1] = 32'd0;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, OP_MFHI, 32'd0, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, OP_AND, 32'd0, 32'd0);
        sample(1'b0, res, z, ov, vo, rdy);
        checks++; if (vo !== 1'b1 || res !== 32'd0) begin
            failures++; $display("FAIL midreset_first_accept_hi got vo=%b res=%h exp vo=1 res=0", vo, res);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            sample(1'b0, res, z, ov, vo, rdy);
            if (vo) vo_seen++;
        end
        checks++; if (vo_seen !== 0) begin failures++; $display("FAIL midreset_stray_valid got=%0d exp=0", vo_seen); end
        transact(1'b0, OP_MFLO, 32'd0, 32'd0, res, z, ov, cyc);
        checks++; if (res !== 32'd0) begin failures++; $display("FAIL midreset_lo got=%h exp=0", res); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_hold();
        test_random(1'b0, 40);
        test_random(1'b1, 40);
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal range 4..64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1, iteration counter width; derived, never overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 valid_in  input  1  request present on op/a/b this cycle.
REQ-006 ready_out  output  1  unit can accept a request this cycle.
REQ-007 op  input  4  operation code (REQ-012).
REQ-008 a, b  input  WIDTH each  operands; a is dividend/minuend.
REQ-009 result  output  WIDTH  registered result of the last completed request.
REQ-010 zero, overflow  output  1 each  result==0; signed overflow of ADD/SUB.
REQ-011 valid_out  output  1  one-cycle pulse: result/zero/overflow updated for one request.

Function
REQ-012 Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT signed, 0011 SLTU, 0100 XOR, 0101 NOR, 1000 MULTU, 1001 DIVU, 1010 MFHI, 1011 MFLO; others are invalid.
REQ-013 Request accepted on a rising edge where valid_in && ready_out; otherwise op/a/b ignored.
REQ-014 FSM states IDLE, MUL, DIV; ready_out = (state==IDLE).
REQ-015 Single-cycle ops (ALU ops, MFHI, MFLO, invalid): result registered at the accept edge; valid_out high the following cycle; state stays IDLE.
REQ-016 Invalid op: result=0, zero=1, overflow=0, valid_out pulses; HI/LO unchanged.
REQ-017 SLT/SLTU: result = {WIDTH-1 zeros, flag}, signed and unsigned compare respectively.
REQ-018 ADD/SUB: result modulo 2^WIDTH; overflow=1 iff signed overflow; overflow=0 for all other ops.
REQ-019 MULTU: IDLE->MUL at accept; exactly WIDTH shift-add iterations, one per cycle; {HI,LO} = a*b unsigned, 2*WIDTH bits.
REQ-020 DIVU: IDLE->DIV at accept; exactly WIDTH restoring-division iterations; LO=a/b, HI=a%b unsigned.
REQ-021 MUL/DIV complete at the WIDTH-th iteration edge: state->IDLE, result=LO, zero=(LO==0), valid_out high the next cycle, equal to WIDTH+1 cycles after accept.
REQ-022 DIVU with b==0: no iterations; LO=all-ones, HI=a, result=all-ones; valid_out the cycle after accept; state stays IDLE.
REQ-023 MFHI/MFLO: result=HI/LO as they stand at the accept edge.
REQ-024 ready_out is high in the cycle valid_out is asserted for MUL/DIV; a request accepted then is legal (back-to-back).
REQ-025 valid_in during MUL/DIV is ignored; no error or queueing; the requester must hold its request.
REQ-026 HI/LO written only by MULTU/DIVU completion; hold otherwise.
REQ-027 Operands latched at accept; a/b changes during MUL/DIV have no effect.

Reset
REQ-028 Reset asserted: state=IDLE; result, HI, LO, counter = 0; zero=1; overflow=0; valid_out=0; ready_out=1.
REQ-029 Reset mid-MUL/DIV aborts the operation; no valid_out; HI/LO = 0.
REQ-030 First accept is possible on the first rising edge after reset deasserts.

Structure
REQ-031 Shared package alu_pkg holds the op enum (REQ-012) and the FSM state enum.
REQ-032 One sub-module, mdu_iter: WIDTH-parametrised, one mul or div step per enable; holds no FSM.
REQ-033 Single-cycle datapath is combinational inside alu_mdu, registered into result.

Verification
REQ-034 WIDTH=32: ADD a=0x7FFFFFFF b=1 -> result 0x80000000, overflow=1, valid_out 1 cycle after accept.
REQ-035 SLT a=0xFFFFFFFF b=1 -> result 1; SLTU with the same operands -> result 0.
REQ-036 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> HI 0xFFFFFFFE, LO 0x00000001, valid_out at cycle 33 after accept; MFHI -> 0xFFFFFFFE.
REQ-037 DIVU a=100 b=7 -> LO 14, HI 2 at cycle 33; DIVU b=0 with a=5 -> LO 0xFFFFFFFF, HI 5 at cycle 1.
REQ-038 Reset at cycle 10 of a MULTU -> no valid_out, HI=LO=0, ready_out=1; valid_in held high during busy -> accepted only when ready_out returns.
REQ-039 WIDTH=8: back-to-back MULTU 15*17 then ADD -> LO 0xFF at cycle 9; ADD accepted in that same cycle.
